nfu3_nbout_writer: RTL

Output-collection stage directly downstream of NFU-3 (sigmoid + rounder). It accepts one Tn-wide vector of rounded neuron outputs per valid cycle, buffers the vectors in a small FIFO, and writes them as whole lines into the NBout SRAM at consecutive addresses. A write-side ready lets NBout stall it. The block tells the controller when a tile's full output set has been written.

---
 rtl/nfu3_nbout_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nfu3_nbout_writer.sv
// NBout write stage behind NFU-3: buffers Tn-wide output vectors in a small FIFO and writes them as
// whole lines at consecutive NBout addresses. Optional NFU back-pressure: define NFU3_NBOUT_STALL_EN.
module nfu3_nbout_writer #(
  parameter int N      = 16,
  parameter int Tn     = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_outputs,
  input  logic              i_valid,
  input  logic [Tn*N-1:0]   i_nfu3_out,
  input  logic              i_nbout_ready,
  output logic              o_nbout_we,
  output logic [ADDR_W-1:0] o_nbout_addr,
  output logic [Tn*N-1:0]   o_nbout_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_nfu_stall
);

  localparam int W  = Tn * N;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_nx;
  logic [W-1:0]      mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [PW:0]       count_r;
  logic [ADDR_W-1:0] num_r, accepted_r, written_r, load_addr_r, addr_r;
  logic [W-1:0]      data_r;
  logic              we_r, overflow_r;

  logic start_acc, full, empty, complete, push, load, drop, last_write;

  assign start_acc  = (state_r == IDLE) && i_start;
  assign full       = (count_r == (PW+1)'(DEPTH));
  assign empty      = (count_r == (PW+1)'(0));
  assign complete   = we_r && i_nbout_ready;
  // No same-cycle bypass: a full FIFO refuses the push even if the head leaves this cycle.
  assign push       = (state_r == RUN) && i_valid && !full && (accepted_r < num_r);
  assign load       = (state_r == RUN) && !empty && (!we_r || complete);
  assign drop       = i_valid && !push;
  assign last_write = complete && (written_r == num_r - ADDR_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) state_nx = (i_num_outputs == ADDR_W'(0)) ? DONE : RUN;
        else         state_nx = IDLE;
      end
      RUN: begin
        if (last_write) state_nx = DONE;
        else            state_nx = RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage; payload needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= i_nfu3_out;
  end

  // FIFO pointers, tile counters, output register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      num_r       <= '0;
      accepted_r  <= '0;
      written_r   <= '0;
      load_addr_r <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      we_r        <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (start_acc) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      num_r       <= i_num_outputs;
      accepted_r  <= '0;
      written_r   <= '0;
      load_addr_r <= i_base_addr;
      we_r        <= 1'b0;
      overflow_r  <= drop;
    end else begin
      if (push) begin
        wr_ptr_r   <= wr_ptr_r + PW'(1);
        accepted_r <= accepted_r + ADDR_W'(1);
      end
      // load_addr_r runs one step ahead of written_r while a write is pending.
      if (load) begin
        rd_ptr_r    <= rd_ptr_r + PW'(1);
        we_r        <= 1'b1;
        addr_r      <= load_addr_r;
        data_r      <= mem_r[rd_ptr_r];
        load_addr_r <= load_addr_r + ADDR_W'(1);
      end else if (complete) begin
        we_r <= 1'b0;
      end
      if (complete) written_r <= written_r + ADDR_W'(1);
      case ({push, load})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop) overflow_r <= 1'b1;
    end
  end

  assign o_nbout_we   = we_r;
  assign o_nbout_addr = addr_r;
  assign o_nbout_data = data_r;
  assign o_busy       = (state_r != IDLE);
  assign o_done       = (state_r == DONE);
  assign o_overflow   = overflow_r;

`ifdef NFU3_NBOUT_STALL_EN
  // Two free slots cover the NFU-3 stages already in flight when stall is seen.
  assign o_nfu_stall = (state_r == RUN) && (count_r >= (PW+1)'(DEPTH - 2));
`else
  assign o_nfu_stall = 1'b0;
`endif

endmodule
